mmio_bus_arbiter: RTL and testbench
===================================

Name: mmio_bus_arbiter

Overview:
- Two-master WISHBONE arbiter in front of the MMIO subsystem.
- Lets the CPU core (M0) and a secondary master (M1, e.g. a debug/DMA bridge) share the single `mmio_sys` slave port.
- Round-robin grant, held for a whole CYC; a per-transfer watchdog keeps a dead slot from hanging the bus.
- Sits between the masters and `mmio_sys`; pure bus plumbing, no address decode.

Parameters:
- ADDR_W, `MMIO_ADDR_WIDTH: address width, both masters and slave side.
- DATA_W, `DATA_WIDTH (32): data width.
- TIMEOUT, 255: cycles STB may wait for ACK before the arbiter self-acks (1..65535).
- TO_DATA, 32'hDEAD_BEEF: read data returned on a timeout ack.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  synchronous, active-high reset
- M0_ADDR_I  in  ADDR_W  master 0 address
- M0_DAT_I  in  DATA_W  master 0 write data
- M0_DAT_O  out  DATA_W  master 0 read data
- M0_CYC_I / M0_STB_I / M0_WE_I  in  1 each  master 0 cycle, strobe, write enable
- M0_ACK_O  out  1  master 0 acknowledge
- M1_ADDR_I, M1_DAT_I, M1_DAT_O, M1_CYC_I, M1_STB_I, M1_WE_I, M1_ACK_O: same as M0, for master 1
- ADDR_O  out  ADDR_W  slave address
- DAT_O  out  DATA_W  slave write data
- DAT_I  in  DATA_W  slave read data
- CYC_O / STB_O / WE_O  out  1 each  slave cycle, strobe, write enable
- ACK_I  in  1  slave acknowledge
- timeout_flag  out  1  sticky: a timeout has occurred since reset
- timeout_src  out  1  master that suffered the most recent timeout

Behaviour:
- FSM states: IDLE, GNT0, GNT1. State is registered.
- Slave-side outputs and master-side returns are combinational from state.

Arbitration:
- IDLE, no CYC asserted: stay in IDLE.
- IDLE, only Mx_CYC_I asserted: go to GNTx.
- IDLE, both asserted: grant the master not granted last. `last_grant` reset value is 1, so M0 wins the first tie.
- GNTx: stay while Mx_CYC_I=1. When Mx_CYC_I=0, go to IDLE and set `last_grant`=x.
- There is always one IDLE cycle between grants; a master cannot be granted back-to-back across a CYC drop.
- Arbitration latency: CYC asserted at edge n is first seen on CYC_O after edge n+1.

Datapath:
- In GNTx: ADDR_O, DAT_O, CYC_O, STB_O and WE_O follow Mx. Mx_ACK_O = ACK_I. Mx_DAT_O = DAT_I.
- Non-granted master: ACK_O=0, DAT_O=0.
- In IDLE: CYC_O, STB_O, WE_O are 0; ADDR_O and DAT_O are 0.
- Slave signals are not registered, so there is no added latency inside a grant. Pipelined back-to-back STBs within one CYC pass straight through.

Watchdog:
- 16-bit counter `to_cnt`. It increments each cycle in GNTx with STB_O=1 and ACK_I=0.
- It clears on ACK_I, on leaving GNTx, or on reaching TIMEOUT.
- Timeout: in the cycle `to_cnt`==TIMEOUT-1 with still no ACK_I:
  - Mx_ACK_O=1 and Mx_DAT_O=TO_DATA for that cycle, regardless of ACK_I=0.
  - timeout_flag is set (sticky).
  - timeout_src=x.
- A late slave ACK_I arriving after a timeout ack is forwarded unchanged; masters must tolerate it.
- ACK_I in the same cycle as the timeout condition: the slave ack wins (data = DAT_I) and no timeout is recorded.

Reset:
- RST_I at the next edge forces: state=IDLE, `last_grant`=1, `to_cnt`=0, timeout_flag=0, timeout_src=0.
- All outputs therefore read 0 in the cycle after the reset edge.
- Reset mid-transfer aborts the cycle with no ack.

Decomposition:
- Add to `vanilla_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_t`
  - `ARB_TO_DATA` localparam (default value of TO_DATA)
- One sub-module, `wb_watchdog`: the timeout counter with TIMEOUT parameter, inputs `en`/`ack`/`clr`, output `expire`.
- Arbiter FSM and muxing stay in `mmio_bus_arbiter`.

Test Plan:
- M0 alone reads address 0x10, slave acks after 2 cycles with 0x1234_5678 -> CYC_O rises 1 cycle after M0_CYC_I; M0_DAT_O=0x1234_5678 with M0_ACK_O; M1_ACK_O stays 0.
- M0 and M1 raise CYC in the same cycle out of reset -> GNT0 first; after M0 drops CYC, exactly one IDLE cycle, then GNT1.
- Both held requesting continuously, each CYC doing 1 transfer, for 6 transfers -> grant order 0,1,0,1,0,1.
- Slave never acks M1 write, TIMEOUT=8 -> M1_ACK_O pulses on the 8th STB cycle with M1_DAT_O=0xDEAD_BEEF; timeout_flag=1, timeout_src=1; flag remains 1 after the next normal transfer.
- ACK_I arrives in exactly the timeout cycle -> data = DAT_I, timeout_flag stays 0.
- RST_I asserted for 1 cycle mid-GNT1 -> next cycle state IDLE, CYC_O=0, timeout_flag=0; subsequent simultaneous requests grant M0.

Source files
------------

// File: rtl/vanilla_pkg.sv
// Shared MMIO subsystem types and defaults: bus widths and the arbiter state/timeout constants.
package vanilla_pkg;

  localparam int unsigned MMIO_ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned ARB_TIMEOUT     = 255;
  localparam int unsigned ARB_CNT_W       = 16;

  localparam logic [31:0] ARB_TO_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT0,
    ARB_GNT1
  } arb_state_t;

endpackage

// File: rtl/wb_watchdog.sv
// Per-transfer stall counter: flags the cycle in which an unacknowledged strobe has waited TIMEOUT cycles.
module wb_watchdog
  import vanilla_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ack,
  input  logic clr,
  output logic expire
);

  logic [ARB_CNT_W-1:0] to_cnt_q;
  logic [ARB_CNT_W-1:0] to_cnt_d;

  // A slave ack in the final cycle beats the timeout.
  assign expire = en && !ack && (to_cnt_q == ARB_CNT_W'(TIMEOUT - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (clr || ack || expire) begin
      to_cnt_d = '0;
    end else if (en) begin
      to_cnt_d = to_cnt_q + ARB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin WISHBONE arbiter in front of mmio_sys; grant held per CYC, watchdog self-acks stalls.
module mmio_bus_arbiter
  import vanilla_pkg::*;
#(
  parameter int unsigned        ADDR_W  = MMIO_ADDR_WIDTH,
  parameter int unsigned        DATA_W  = DATA_WIDTH,
  parameter int unsigned        TIMEOUT = ARB_TIMEOUT,
  parameter logic [DATA_W-1:0]  TO_DATA = DATA_W'(ARB_TO_DATA)
) (
  input  logic              CLK_I,
  input  logic              RST_I,

  input  logic [ADDR_W-1:0] M0_ADDR_I,
  input  logic [DATA_W-1:0] M0_DAT_I,
  output logic [DATA_W-1:0] M0_DAT_O,
  input  logic              M0_CYC_I,
  input  logic              M0_STB_I,
  input  logic              M0_WE_I,
  output logic              M0_ACK_O,

  input  logic [ADDR_W-1:0] M1_ADDR_I,
  input  logic [DATA_W-1:0] M1_DAT_I,
  output logic [DATA_W-1:0] M1_DAT_O,
  input  logic              M1_CYC_I,
  input  logic              M1_STB_I,
  input  logic              M1_WE_I,
  output logic              M1_ACK_O,

  output logic [ADDR_W-1:0] ADDR_O,
  output logic [DATA_W-1:0] DAT_O,
  input  logic [DATA_W-1:0] DAT_I,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  input  logic              ACK_I,

  output logic              timeout_flag,
  output logic              timeout_src
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       timeout_flag_q, timeout_flag_d;
  logic       timeout_src_q, timeout_src_d;

  logic       wdg_en;
  logic       wdg_clr;
  logic       wdg_expire;

  // Watchdog enable is built from inputs directly to keep it out of the mux process.
  assign wdg_en  = ((state_q == ARB_GNT0) && M0_STB_I) || ((state_q == ARB_GNT1) && M1_STB_I);
  assign wdg_clr = (state_q == ARB_IDLE);

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wb_watchdog (
    .clk    (CLK_I),
    .rst    (RST_I),
    .en     (wdg_en),
    .ack    (ACK_I),
    .clr    (wdg_clr),
    .expire (wdg_expire)
  );

  assign timeout_flag = timeout_flag_q;
  assign timeout_src  = timeout_src_q;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    timeout_flag_d = timeout_flag_q;
    timeout_src_d  = timeout_src_q;
    ADDR_O         = '0;
    DAT_O          = '0;
    CYC_O          = 1'b0;
    STB_O          = 1'b0;
    WE_O           = 1'b0;
    M0_ACK_O       = 1'b0;
    M0_DAT_O       = '0;
    M1_ACK_O       = 1'b0;
    M1_DAT_O       = '0;

    case (state_q)
      ARB_IDLE: begin
        // On a tie the master not served last wins.
        if (M0_CYC_I && M1_CYC_I) begin
          state_d = last_grant_q ? ARB_GNT0 : ARB_GNT1;
        end else if (M0_CYC_I) begin
          state_d = ARB_GNT0;
        end else if (M1_CYC_I) begin
          state_d = ARB_GNT1;
        end
      end

      ARB_GNT0: begin
        ADDR_O   = M0_ADDR_I;
        DAT_O    = M0_DAT_I;
        CYC_O    = M0_CYC_I;
        STB_O    = M0_STB_I;
        WE_O     = M0_WE_I;
        M0_ACK_O = ACK_I || wdg_expire;
        M0_DAT_O = wdg_expire ? TO_DATA : DAT_I;
        if (wdg_expire) begin
          timeout_flag_d = 1'b1;
          timeout_src_d  = 1'b0;
        end
        if (!M0_CYC_I) begin
          state_d      = ARB_IDLE;
          last_grant_d = 1'b0;
        end
      end

      ARB_GNT1: begin
        ADDR_O   = M1_ADDR_I;
        DAT_O    = M1_DAT_I;
        CYC_O    = M1_CYC_I;
        STB_O    = M1_STB_I;
        WE_O     = M1_WE_I;
        M1_ACK_O = ACK_I || wdg_expire;
        M1_DAT_O = wdg_expire ? TO_DATA : DAT_I;
        if (wdg_expire) begin
          timeout_flag_d = 1'b1;
          timeout_src_d  = 1'b1;
        end
        if (!M1_CYC_I) begin
          state_d      = ARB_IDLE;
          last_grant_d = 1'b1;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q        <= ARB_IDLE;
      last_grant_q   <= 1'b1;
      timeout_flag_q <= 1'b0;
      timeout_src_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      timeout_flag_q <= timeout_flag_d;
      timeout_src_q  <= timeout_src_d;
    end
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mmio_bus_arbiter;
  import vanilla_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;
  localparam logic [31:0] TOD = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_addr, m1_addr, addr_o;
  logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, dat_o, dat_i;
  logic          m0_cyc, m0_stb, m0_we, m0_ack;
  logic          m1_cyc, m1_stb, m1_we, m1_ack;
  logic          cyc_o, stb_o, we_o, ack_i;
  logic          t_flag, t_src;

  always #5 clk = ~clk;

  mmio_bus_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO),
    .TO_DATA (TOD)
  ) dut (
    .CLK_I        (clk),
    .RST_I        (rst),
    .M0_ADDR_I    (m0_addr),
    .M0_DAT_I     (m0_wdat),
    .M0_DAT_O     (m0_rdat),
    .M0_CYC_I     (m0_cyc),
    .M0_STB_I     (m0_stb),
    .M0_WE_I      (m0_we),
    .M0_ACK_O     (m0_ack),
    .M1_ADDR_I    (m1_addr),
    .M1_DAT_I     (m1_wdat),
    .M1_DAT_O     (m1_rdat),
    .M1_CYC_I     (m1_cyc),
    .M1_STB_I     (m1_stb),
    .M1_WE_I      (m1_we),
    .M1_ACK_O     (m1_ack),
    .ADDR_O       (addr_o),
    .DAT_O        (dat_o),
    .DAT_I        (dat_i),
    .CYC_O        (cyc_o),
    .STB_O        (stb_o),
    .WE_O         (we_o),
    .ACK_I        (ack_i),
    .timeout_flag (t_flag),
    .timeout_src  (t_src)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: owner -1 means nobody holds the bus; waited counts stalled strobe cycles.
  int owner  = -1;
  int last   = 1;
  int waited = 0;
  bit flag   = 1'b0;
  int src    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit owner_stb();
    if (owner == 0) return m0_stb;
    if (owner == 1) return m1_stb;
    return 1'b0;
  endfunction

  function automatic bit ref_expire();
    return (owner >= 0) && owner_stb() && !ack_i && (waited == int'(TO) - 1);
  endfunction

  task automatic sample();
    logic [63:0] e_slv, e_m0, e_m1;
    bit ex;
    @(negedge clk);
    ex    = ref_expire();
    e_slv = '0;
    e_m0  = '0;
    e_m1  = '0;
    if (owner == 0) begin
      e_slv = {13'd0, m0_cyc, m0_stb, m0_we, m0_addr, m0_wdat};
      e_m0  = {31'd0, ack_i | ex, ex ? TOD : dat_i};
    end else if (owner == 1) begin
      e_slv = {13'd0, m1_cyc, m1_stb, m1_we, m1_addr, m1_wdat};
      e_m1  = {31'd0, ack_i | ex, ex ? TOD : dat_i};
    end
    chk("slave_side", {13'd0, cyc_o, stb_o, we_o, addr_o, dat_o}, e_slv);
    chk("m0_return", {31'd0, m0_ack, m0_rdat}, e_m0);
    chk("m1_return", {31'd0, m1_ack, m1_rdat}, e_m1);
    chk("timeout_status", {62'd0, t_flag, t_src}, {62'd0, flag, 1'(src)});
  endtask

  task automatic advance();
    bit ex;
    @(posedge clk);
    ex = ref_expire();
    if (rst) begin
      owner = -1; last = 1; waited = 0; flag = 1'b0; src = 0;
    end else if (owner >= 0) begin
      if (ex) begin
        flag = 1'b1;
        src  = owner;
      end
      if (ack_i || ex) waited = 0;
      else if (owner_stb()) waited++;
      if (!((owner == 0) ? m0_cyc : m1_cyc)) begin
        last   = owner;
        owner  = -1;
        waited = 0;
      end
    end else begin
      waited = 0;
      if (m0_cyc && m1_cyc) owner = (last == 1) ? 0 : 1;
      else if (m0_cyc)      owner = 0;
      else if (m1_cyc)      owner = 1;
    end
    #1;
  endtask

  task automatic idle_bus();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; ack_i = 0;
  endtask

  int grants[$];
  bit need_drop[2];
  bit down[2];

  initial begin
    rst = 1; m0_addr = '0; m1_addr = '0; m0_wdat = '0; m1_wdat = '0;
    m0_we = 0; m1_we = 0; dat_i = '0;
    idle_bus();
    advance();
    advance();
    rst = 0;
    sample();
    chk("reset_cyc_o", 64'(cyc_o), 64'd0);
    chk("reset_flag", 64'(t_flag), 64'd0);
    advance();

    // M0 alone reads 0x10, acked after two stall cycles
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 16'h0010;
    sample(); chk("t1_idle_cyc", 64'(cyc_o), 64'd0); advance();
    sample(); chk("t1_gnt_cyc", 64'(cyc_o), 64'd1); chk("t1_addr", 64'(addr_o), 64'h10); advance();
    sample(); advance();
    ack_i = 1; dat_i = 32'h1234_5678;
    sample();
    chk("t1_m0_ack", 64'(m0_ack), 64'd1);
    chk("t1_m0_dat", 64'(m0_rdat), 64'h1234_5678);
    chk("t1_m1_ack", 64'(m1_ack), 64'd0);
    advance();
    idle_bus();
    sample(); advance(); sample(); advance();

    // Simultaneous requests out of reset
    rst = 1; advance(); rst = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 16'h00A0;
    m1_cyc = 1; m1_stb = 1; m1_addr = 16'h00B0;
    sample(); chk("t2_idle", 64'(cyc_o), 64'd0); advance();
    ack_i = 1;
    sample(); chk("t2_first_grant", 64'(addr_o), 64'hA0); chk("t2_m0_ack", 64'(m0_ack), 64'd1); advance();
    ack_i = 0; m0_cyc = 0; m0_stb = 0;
    sample(); advance();
    sample(); chk("t2_idle_gap", 64'(cyc_o), 64'd0); advance();
    ack_i = 1;
    sample(); chk("t2_second_grant", {47'd0, cyc_o, addr_o}, {47'd0, 1'b1, 16'h00B0}); advance();
    ack_i = 0; m1_cyc = 0; m1_stb = 0;
    sample(); advance(); sample(); advance();

    // Both request continuously, one transfer per CYC
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; ack_i = 1;
    need_drop = '{0, 0}; down = '{0, 0};
    for (int c = 0; c < 60 && grants.size() < 6; c++) begin
      sample();
      if (m0_ack && m0_stb) begin grants.push_back(0); need_drop[0] = 1; end
      if (m1_ack && m1_stb) begin grants.push_back(1); need_drop[1] = 1; end
      advance();
      if (need_drop[0]) begin m0_cyc = 0; m0_stb = 0; need_drop[0] = 0; down[0] = 1; end
      else if (down[0]) begin m0_cyc = 1; m0_stb = 1; down[0] = 0; end
      if (need_drop[1]) begin m1_cyc = 0; m1_stb = 0; need_drop[1] = 0; down[1] = 1; end
      else if (down[1]) begin m1_cyc = 1; m1_stb = 1; down[1] = 0; end
    end
    chk("t3_grant_count", 64'(grants.size()), 64'd6);
    for (int i = 0; i < grants.size() && i < 6; i++)
      chk($sformatf("t3_order_%0d", i), 64'(grants[i]), 64'(i % 2));
    idle_bus();
    sample(); advance(); sample(); advance(); sample(); advance();

    // M1 write never acked: self-ack on the TO-th strobe cycle
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 16'h0044; m1_wdat = 32'h0000_55AA;
    sample(); advance();
    for (int i = 1; i <= int'(TO); i++) begin
      sample();
      if (i < int'(TO)) chk($sformatf("t4_no_ack_%0d", i), 64'(m1_ack), 64'd0);
      else begin
        chk("t4_to_ack", 64'(m1_ack), 64'd1);
        chk("t4_to_dat", 64'(m1_rdat), 64'hDEAD_BEEF);
      end
      advance();
    end
    sample(); chk("t4_flag", {62'd0, t_flag, t_src}, 64'd3);
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    advance(); sample(); advance();
    m0_cyc = 1; m0_stb = 1; m0_addr = 16'h0020;
    sample(); advance();
    ack_i = 1; dat_i = 32'h0BAD_F00D;
    sample(); chk("t4_normal_ack", 64'(m0_ack), 64'd1); advance();
    idle_bus();
    sample(); chk("t4_flag_sticky", 64'(t_flag), 64'd1); advance();
    sample(); advance();

    // Reset mid-GNT1, then simultaneous requests go to M0
    m1_cyc = 1; m1_stb = 1; m1_addr = 16'h0066;
    sample(); advance();
    sample(); chk("t6_gnt1", 64'(cyc_o), 64'd1);
    rst = 1; advance(); rst = 0;
    m0_cyc = 1; m0_stb = 1; m0_addr = 16'h0055;
    sample();
    chk("t6_cyc_after_rst", 64'(cyc_o), 64'd0);
    chk("t6_flag_after_rst", {62'd0, t_flag, t_src}, 64'd0);
    advance();
    sample(); chk("t6_m0_wins", {47'd0, cyc_o, addr_o}, {47'd0, 1'b1, 16'h0055}); advance();
    idle_bus();
    sample(); advance(); sample(); advance();

    // Slave ack arrives in exactly the timeout cycle
    m0_cyc = 1; m0_stb = 1; m0_addr = 16'h0077;
    sample(); advance();
    for (int i = 1; i <= int'(TO); i++) begin
      if (i == int'(TO)) begin ack_i = 1; dat_i = 32'hCAFE_0001; end
      sample();
      if (i == int'(TO)) chk("t5_slave_wins", {31'd0, m0_ack, m0_rdat}, {31'd0, 1'b1, 32'hCAFE_0001});
      advance();
    end
    ack_i = 0;
    sample(); chk("t5_no_flag", 64'(t_flag), 64'd0); advance();
    idle_bus();
    sample(); advance(); sample(); advance();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if (m0_cyc) begin
        if ($urandom_range(4) == 0) begin m0_cyc = 0; m0_stb = 0; end
        else begin
          m0_stb = ($urandom_range(2) != 0); m0_we = 1'($urandom);
          m0_addr = 16'($urandom); m0_wdat = $urandom;
        end
      end else if ($urandom_range(2) == 0) begin
        m0_cyc = 1; m0_stb = 1; m0_addr = 16'($urandom); m0_wdat = $urandom;
      end
      if (m1_cyc) begin
        if ($urandom_range(4) == 0) begin m1_cyc = 0; m1_stb = 0; end
        else begin
          m1_stb = ($urandom_range(2) != 0); m1_we = 1'($urandom);
          m1_addr = 16'($urandom); m1_wdat = $urandom;
        end
      end else if ($urandom_range(2) == 0) begin
        m1_cyc = 1; m1_stb = 1; m1_addr = 16'($urandom); m1_wdat = $urandom;
      end
      ack_i = (c < 750) ? ($urandom_range(2) == 0) : ($urandom_range(11) == 0);
      dat_i = $urandom;
      rst   = ($urandom_range(199) == 0);
      sample();
      advance();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
